// File: rtl/branch_resolve.sv
// Branch resolution stage: captures a branch request, evaluates its condition
// against one-hot compare flags, and hands off taken/target with a valid/ready handshake.
module branch_resolve #(
  parameter logic [15:0] PC_STEP = 16'd1,
  parameter int          CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [15:0]      pc,
  input  logic [15:0]      offset,
  input  logic [2:0]       cond,
  input  logic             lt,
  input  logic             gt,
  input  logic             eq,
  output logic             valid_out,
  input  logic             ready_out,
  output logic             taken,
  output logic [15:0]      target,
  output logic             flush,
  output logic             err,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    OUT  = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    C_EQ     = 3'd0,
    C_NE     = 3'd1,
    C_LT     = 3'd2,
    C_GT     = 3'd3,
    C_LE     = 3'd4,
    C_GE     = 3'd5,
    C_ALWAYS = 3'd6,
    C_NEVER  = 3'd7
  } cond_e;

  state_e           state_q, state_d;

  logic [15:0]      pc_q, pc_d;
  logic [15:0]      offset_q, offset_d;
  logic [2:0]       cond_q, cond_d;
  logic [2:0]       flags_q, flags_d;   // {lt, gt, eq}

  logic             taken_q, taken_d;
  logic [15:0]      target_q, target_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             flags_onehot;
  logic             cond_true;
  logic             handshake;

  // Condition truth table over the latched request.
  always_comb begin
    flags_onehot = (flags_q == 3'b100) || (flags_q == 3'b010) || (flags_q == 3'b001);
    cond_true    = 1'b0;
    case (cond_e'(cond_q))
      C_EQ:     cond_true = flags_q[0];
      C_NE:     cond_true = ~flags_q[0];
      C_LT:     cond_true = flags_q[2];
      C_GT:     cond_true = flags_q[1];
      C_LE:     cond_true = flags_q[2] | flags_q[0];
      C_GE:     cond_true = flags_q[1] | flags_q[0];
      C_ALWAYS: cond_true = 1'b1;
      C_NEVER:  cond_true = 1'b0;
      default:  cond_true = 1'b0;
    endcase
  end

  // Next-state, request capture and result registration.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    offset_d = offset_q;
    cond_d   = cond_q;
    flags_d  = flags_q;
    taken_d  = taken_q;
    target_d = target_q;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (valid_in) begin
          pc_d     = pc;
          offset_d = offset;
          cond_d   = cond;
          flags_d  = {lt, gt, eq};
          state_d  = EVAL;
        end
      end
      EVAL: begin
        err_d    = ~flags_onehot;
        taken_d  = flags_onehot & cond_true;
        target_d = (flags_onehot & cond_true) ? (pc_q + offset_q) : (pc_q + PC_STEP);
        state_d  = OUT;
      end
      OUT: begin
        if (ready_out) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign handshake = (state_q == OUT) && ready_out;

  // Saturating taken counter; a clear wins over a coincident increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (handshake && taken_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      taken_q  <= 1'b0;
      target_q <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      taken_q  <= taken_d;
      target_q <= target_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // NOTE: the captured request is only read after it has been loaded in IDLE,
  // so these datapath flops need no reset.
  always_ff @(posedge clk) begin
    pc_q     <= pc_d;
    offset_q <= offset_d;
    cond_q   <= cond_d;
    flags_q  <= flags_d;
  end

  assign ready_in  = (state_q == IDLE);
  assign valid_out = (state_q == OUT);
  assign taken     = taken_q;
  assign target    = target_q;
  assign flush     = (state_q == OUT) && taken_q;
  assign err       = err_q;
  assign taken_cnt = cnt_q;

endmodule
